// File: rtl/mmio_timer_pkg.sv
// Shared definitions for the machine-timer peripheral and other data-bus
// responders: access-mode encodings, register offsets, CTRL layout and a
// byte-lane merge helper.
package mmio_timer_pkg;

    // funct3 load/store access modes
    localparam logic [2:0] MODE_B  = 3'b000;
    localparam logic [2:0] MODE_H  = 3'b001;
    localparam logic [2:0] MODE_W  = 3'b010;
    localparam logic [2:0] MODE_BU = 3'b100;
    localparam logic [2:0] MODE_HU = 3'b101;

    // Word offsets inside the 32-byte register window (addr[4:2])
    typedef enum logic [2:0] {
        REG_MTIME_LO    = 3'd0,
        REG_MTIME_HI    = 3'd1,
        REG_MTIMECMP_LO = 3'd2,
        REG_MTIMECMP_HI = 3'd3,
        REG_CTRL        = 3'd4,
        REG_STATUS      = 3'd5
    } reg_off_e;

    // CTRL register bit positions
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_PRESC_LSB  = 8;

    // Replace the enabled byte lanes of old_word with those of new_word
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/mmio_lane_ctrl.sv
// Byte-lane logic for a 32-bit data-bus responder: alignment / mode
// legality, store byte enables and lane placement, load extract and extend.
module mmio_lane_ctrl
    import mmio_timer_pkg::*;
(
    input  logic [2:0]  mode_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        is_store_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic        err_o,
    output logic [3:0]  be_o,
    output logic [31:0] wlane_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted_s;

    // Legality check and byte-enable generation from mode and low address bits
    always_comb begin
        err_o = 1'b0;
        be_o  = 4'b0000;
        case (mode_i)
            MODE_B: begin
                be_o = 4'b0001 << addr_lo_i;
            end
            MODE_BU: begin
                err_o = is_store_i;
                be_o  = 4'b0001 << addr_lo_i;
            end
            MODE_H: begin
                err_o = addr_lo_i[0];
                be_o  = 4'b0011 << addr_lo_i;
            end
            MODE_HU: begin
                err_o = addr_lo_i[0] | is_store_i;
                be_o  = 4'b0011 << addr_lo_i;
            end
            MODE_W: begin
                err_o = (addr_lo_i != 2'b00);
                be_o  = 4'b1111;
            end
            default: begin
                err_o = 1'b1;
                be_o  = 4'b0000;
            end
        endcase
    end

    // Store data is LSB-aligned on the bus; move it onto the addressed lanes
    assign wlane_o   = wdata_i << {addr_lo_i, 3'b000};
    assign shifted_s = rword_i >> {addr_lo_i, 3'b000};

    // Load extract: pick the addressed byte/half and sign- or zero-extend
    always_comb begin
        rdata_o = 32'h0000_0000;
        case (mode_i)
            MODE_B:  rdata_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
            MODE_BU: rdata_o = {24'h00_0000, shifted_s[7:0]};
            MODE_H:  rdata_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
            MODE_HU: rdata_o = {16'h0000, shifted_s[15:0]};
            MODE_W:  rdata_o = shifted_s;
            default: rdata_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped machine timer: 64-bit mtime with prescaler, 64-bit
// mtimecmp, sticky pending flag and registered interrupt level.
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_F000,
    parameter int          PRESC_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic [2:0]  mem_acc_mode,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        acc_err,
    output logic        timer_interrupt
);

    logic [63:0]        mtime_q, mtime_d;
    logic [63:0]        mtimecmp_q, mtimecmp_d;
    logic               en_q, en_d;
    logic               irq_en_q, irq_en_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic               pending_q, pending_d;
    logic [31:0]        hi_shadow_q, hi_shadow_d;
    logic               timer_interrupt_q;

    logic [2:0]  off_s;
    logic        lane_err_s;
    logic [3:0]  be_s;
    logic [31:0] wlane_s;
    logic [31:0] ext_s;
    logic [31:0] ctrl_word_s;
    logic [31:0] rword_s;
    logic [31:0] wold_s;
    logic [31:0] merged_s;
    logic        wr_ok_s;
    logic        rd_ok_s;
    logic        tick_s;
    logic        match_s;

    assign off_s = addr[4:2];
    assign hit   = (addr[31:5] == BASE_ADDR[31:5]);

    mmio_lane_ctrl u_lane (
        .mode_i     (mem_acc_mode),
        .addr_lo_i  (addr[1:0]),
        .is_store_i (wr_en),
        .wdata_i    (wdata),
        .rword_i    (rword_s),
        .err_o      (lane_err_s),
        .be_o       (be_s),
        .wlane_o    (wlane_s),
        .rdata_o    (ext_s)
    );

    // A simultaneous load and store is handled as the store but still flagged
    assign acc_err = hit & (rd_en | wr_en) & (lane_err_s | (rd_en & wr_en));
    assign wr_ok_s = hit & wr_en & ~lane_err_s;
    assign rd_ok_s = hit & rd_en & ~acc_err;
    assign rdata   = rd_ok_s ? ext_s : 32'h0000_0000;

    assign match_s         = (mtime_q >= mtimecmp_q);
    assign tick_s          = en_q & (presc_cnt_q == presc_q);
    assign merged_s        = merge_lanes(wold_s, wlane_s, be_s);
    assign timer_interrupt = timer_interrupt_q;

    // Assemble the CTRL view from its fields; unused bits read as zero
    always_comb begin
        ctrl_word_s                                = 32'h0000_0000;
        ctrl_word_s[CTRL_EN_BIT]                   = en_q;
        ctrl_word_s[CTRL_IRQ_EN_BIT]               = irq_en_q;
        ctrl_word_s[CTRL_PRESC_LSB +: PRESC_W]     = presc_q;
    end

    // Load view of each register; MTIME_HI returns the shadow captured by the LO read
    always_comb begin
        rword_s = 32'h0000_0000;
        case (off_s)
            REG_MTIME_LO:    rword_s = mtime_q[31:0];
            REG_MTIME_HI:    rword_s = hi_shadow_q;
            REG_MTIMECMP_LO: rword_s = mtimecmp_q[31:0];
            REG_MTIMECMP_HI: rword_s = mtimecmp_q[63:32];
            REG_CTRL:        rword_s = ctrl_word_s;
            REG_STATUS:      rword_s = {31'h0000_0000, pending_q};
            default:         rword_s = 32'h0000_0000;
        endcase
    end

    // Store view of each register, used as the base for partial-lane merges
    always_comb begin
        wold_s = 32'h0000_0000;
        case (off_s)
            REG_MTIME_LO:    wold_s = mtime_q[31:0];
            REG_MTIME_HI:    wold_s = mtime_q[63:32];
            REG_MTIMECMP_LO: wold_s = mtimecmp_q[31:0];
            REG_MTIMECMP_HI: wold_s = mtimecmp_q[63:32];
            REG_CTRL:        wold_s = ctrl_word_s;
            default:         wold_s = 32'h0000_0000;
        endcase
    end

    // Next state: prescaler/counter advance, compare, then bus writes override
    always_comb begin
        mtime_d     = mtime_q;
        mtimecmp_d  = mtimecmp_q;
        en_d        = en_q;
        irq_en_d    = irq_en_q;
        presc_d     = presc_q;
        presc_cnt_d = presc_cnt_q;
        pending_d   = pending_q | match_s;
        hi_shadow_d = hi_shadow_q;

        if (!en_q) begin
            presc_cnt_d = {PRESC_W{1'b0}};
        end else if (tick_s) begin
            presc_cnt_d = {PRESC_W{1'b0}};
        end else begin
            presc_cnt_d = presc_cnt_q + PRESC_W'(1'b1);
        end

        if (tick_s) begin
            mtime_d = mtime_q + 64'd1;
        end else begin
            mtime_d = mtime_q;
        end

        if (rd_ok_s && (off_s == REG_MTIME_LO)) begin
            hi_shadow_d = mtime_q[63:32];
        end else begin
            hi_shadow_d = hi_shadow_q;
        end

        if (wr_ok_s) begin
            case (off_s)
                REG_MTIME_LO:    mtime_d = {mtime_q[63:32], merged_s};
                REG_MTIME_HI:    mtime_d = {merged_s, mtime_q[31:0]};
                REG_MTIMECMP_LO: mtimecmp_d[31:0]  = merged_s;
                REG_MTIMECMP_HI: mtimecmp_d[63:32] = merged_s;
                REG_CTRL: begin
                    en_d        = merged_s[CTRL_EN_BIT];
                    irq_en_d    = merged_s[CTRL_IRQ_EN_BIT];
                    presc_d     = merged_s[CTRL_PRESC_LSB +: PRESC_W];
                    presc_cnt_d = {PRESC_W{1'b0}};
                end
                REG_STATUS: begin
                    // A live match keeps pending set even against a clear
                    if (be_s[0] && wlane_s[0] && !match_s) begin
                        pending_d = 1'b0;
                    end else begin
                        pending_d = pending_q | match_s;
                    end
                end
                default: begin
                    mtime_d = mtime_d;
                end
            endcase
        end else begin
            mtimecmp_d = mtimecmp_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_q           <= 64'h0000_0000_0000_0000;
            mtimecmp_q        <= 64'hFFFF_FFFF_FFFF_FFFF;
            en_q              <= 1'b0;
            irq_en_q          <= 1'b0;
            presc_q           <= {PRESC_W{1'b0}};
            presc_cnt_q       <= {PRESC_W{1'b0}};
            pending_q         <= 1'b0;
            hi_shadow_q       <= 32'h0000_0000;
            timer_interrupt_q <= 1'b0;
        end else begin
            mtime_q           <= mtime_d;
            mtimecmp_q        <= mtimecmp_d;
            en_q              <= en_d;
            irq_en_q          <= irq_en_d;
            presc_q           <= presc_d;
            presc_cnt_q       <= presc_cnt_d;
            pending_q         <= pending_d;
            hi_shadow_q       <= hi_shadow_d;
            timer_interrupt_q <= irq_en_q & pending_q;
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// Bench for mmio_timer: directed scenarios plus random bus traffic, all
// checked every cycle against a behavioural model of the timer.
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'h0000_F000;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] addr;
    logic [2:0]  mode;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;
    logic        acc_err;
    logic        timer_interrupt;

    int n_vec = 0;
    int n_err = 0;

    mmio_timer #(.BASE_ADDR(BASE), .PRESC_W(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .rd_en           (rd_en),
        .wr_en           (wr_en),
        .addr            (addr),
        .mem_acc_mode    (mode),
        .wdata           (wdata),
        .rdata           (rdata),
        .hit             (hit),
        .acc_err         (acc_err),
        .timer_interrupt (timer_interrupt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    logic [63:0] m_mtime, m_cmp;
    logic        m_en, m_irq, m_pend, m_ti;
    logic [7:0]  m_presc, m_cnt;
    logic [31:0] m_shadow;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mtime  = 64'd0;
        m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
        m_en     = 1'b0;
        m_irq    = 1'b0;
        m_pend   = 1'b0;
        m_ti     = 1'b0;
        m_presc  = 8'd0;
        m_cnt    = 8'd0;
        m_shadow = 32'd0;
    endtask

    function automatic int acc_size(input logic [2:0] m);
        if (m[1:0] == 2'd0) return 1;
        else if (m[1:0] == 2'd1) return 2;
        else return 4;
    endfunction

    function automatic bit aligned(input logic [31:0] a, input logic [2:0] m);
        return (int'(a[1:0]) % acc_size(m)) == 0;
    endfunction

    function automatic bit ld_legal(input logic [31:0] a, input logic [2:0] m);
        return (m == 3'd0 || m == 3'd1 || m == 3'd2 || m == 3'd4 || m == 3'd5) && aligned(a, m);
    endfunction

    function automatic bit st_legal(input logic [31:0] a, input logic [2:0] m);
        return (m == 3'd0 || m == 3'd1 || m == 3'd2) && aligned(a, m);
    endfunction

    function automatic bit in_win(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd32);
    endfunction

    function automatic logic [31:0] m_word(input int off, input bit live_hi);
        case (off)
            0: return m_mtime[31:0];
            1: return live_hi ? m_mtime[63:32] : m_shadow;
            2: return m_cmp[31:0];
            3: return m_cmp[63:32];
            4: return {16'h0000, m_presc, 6'h00, m_irq, m_en};
            5: return {31'h0, m_pend};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] m);
        longint v;
        longint span;
        int     sz;
        sz   = acc_size(m);
        span = longint'(1) << (8 * sz);
        v    = longint'(m_word(int'(a[4:2]), 1'b0) >> (8 * int'(a[1:0]))) % span;
        if ((m == 3'd0 || m == 3'd1) && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] old, input logic [31:0] a,
                                            input logic [2:0] m, input logic [31:0] d);
        logic [31:0] w;
        int lane;
        w = old;
        for (int k = 0; k < acc_size(m); k++) begin
            lane = int'(a[1:0]) + k;
            w[8*lane +: 8] = d[8*k +: 8];
        end
        return w;
    endfunction

    // Advance the model by one clock edge given that cycle's bus inputs
    task automatic model_step(input bit rs, input bit r, input bit w, input logic [31:0] a,
                              input logic [2:0] m, input logic [31:0] d);
        bit          hv, do_wr, do_rd, match, tick;
        int          off;
        logic [31:0] nw, n_shadow;
        logic [63:0] n_mtime, n_cmp;
        logic        n_en, n_irq, n_pend, n_ti;
        logic [7:0]  n_presc, n_cnt;
        if (rs) begin
            model_reset();
            return;
        end
        hv    = in_win(a);
        off   = int'(a[4:2]);
        do_wr = hv && w && st_legal(a, m);
        do_rd = hv && r && !w && ld_legal(a, m);
        match = (m_mtime >= m_cmp);
        tick  = m_en && (m_cnt == m_presc);
        n_mtime  = tick ? m_mtime + 64'd1 : m_mtime;
        n_cnt    = (m_en && !tick) ? m_cnt + 8'd1 : 8'd0;
        n_cmp    = m_cmp;
        n_en     = m_en;
        n_irq    = m_irq;
        n_presc  = m_presc;
        n_pend   = m_pend || match;
        n_ti     = m_irq && m_pend;
        n_shadow = (do_rd && off == 0) ? m_mtime[63:32] : m_shadow;
        if (do_wr) begin
            nw = m_store(m_word(off, 1'b1), a, m, d);
            case (off)
                0: n_mtime = {m_mtime[63:32], nw};
                1: n_mtime = {nw, m_mtime[31:0]};
                2: n_cmp[31:0] = nw;
                3: n_cmp[63:32] = nw;
                4: begin
                    n_en = nw[0]; n_irq = nw[1]; n_presc = nw[15:8]; n_cnt = 8'd0;
                end
                5: if (a[1:0] == 2'd0 && d[0] && !match) n_pend = 1'b0;
                default: ;
            endcase
        end
        m_mtime = n_mtime; m_cmp = n_cmp; m_en = n_en; m_irq = n_irq; m_presc = n_presc;
        m_cnt = n_cnt; m_pend = n_pend; m_ti = n_ti; m_shadow = n_shadow;
    endtask

    // One bus cycle: drive, check combinational and registered outputs, clock
    task automatic op(input bit rs, input bit r, input bit w, input logic [31:0] a,
                      input logic [2:0] m, input logic [31:0] d,
                      output logic [31:0] rd_o, output logic err_o, output logic hit_o);
        bit          hv;
        logic        e_err;
        logic [31:0] e_rd;
        rst = rs; rd_en = r; wr_en = w; addr = a; mode = m; wdata = d;
        hv    = in_win(a);
        e_err = hv && (r || w) && (w ? (!st_legal(a, m) || r) : !ld_legal(a, m));
        e_rd  = (hv && r && !w && ld_legal(a, m)) ? m_load(a, m) : 32'h0;
        #3;
        chk("hit", hit, hv);
        chk("acc_err", acc_err, e_err);
        chk("rdata", rdata, e_rd);
        chk("timer_interrupt", timer_interrupt, m_ti);
        rd_o = rdata; err_o = acc_err; hit_o = hit;
        @(posedge clk);
        model_step(rs, r, w, a, m, d);
        #1;
    endtask

    logic [31:0] rv;
    logic        ev, hv_o;

    task automatic sw(input logic [31:0] off, input logic [31:0] d);
        op(1'b0, 1'b0, 1'b1, BASE + off, 3'b010, d, rv, ev, hv_o);
    endtask

    task automatic ld(input logic [31:0] off, input logic [2:0] m);
        op(1'b0, 1'b1, 1'b0, BASE + off, m, 32'h0, rv, ev, hv_o);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(1'b0, 1'b0, 1'b0, 32'h0, 3'b010, 32'h0, rv, ev, hv_o);
    endtask

    initial begin
        logic [31:0] a, d;
        logic [2:0]  m;
        bit          r, w, rs;
        int          kind;

        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = 32'h0; mode = 3'b010; wdata = 32'h0;
        repeat (2) @(posedge clk);
        model_reset();
        #1;

        // Reset state
        ld(32'h8, 3'b010); chk("rst_cmp_lo", rv, 32'hFFFF_FFFF);
        ld(32'h0, 3'b010); chk("rst_mtime_lo", rv, 32'h0);
        ld(32'h10, 3'b010); chk("rst_ctrl", rv, 32'h0);

        // 1: free run at presc=0
        sw(32'h10, 32'h0000_0001);
        idle(10);
        ld(32'h0, 3'b010); chk("t1_mtime_lo", rv, 32'd10);
        ld(32'h4, 3'b010); chk("t1_mtime_hi", rv, 32'd0);

        // 2: prescaler 3, then freeze
        sw(32'h10, 32'h0);
        sw(32'h0, 32'h0);
        sw(32'h4, 32'h0);
        sw(32'h10, 32'h0000_0301);
        idle(40);
        ld(32'h0, 3'b010); chk("t2_presc3", rv, 32'd10);
        sw(32'h10, 32'h0);
        idle(20);
        ld(32'h0, 3'b010); chk("t2_frozen", rv, 32'd10);

        // 3: carry into the high word, shadowed high read
        sw(32'h4, 32'h0);
        sw(32'h0, 32'hFFFF_FFFF);
        sw(32'h10, 32'h1);
        sw(32'h10, 32'h0);
        ld(32'h4, 3'b010); chk("t3_hi_stale", rv, 32'd0);
        ld(32'h0, 3'b010); chk("t3_lo_wrap", rv, 32'd0);
        ld(32'h4, 3'b010); chk("t3_hi_fresh", rv, 32'd1);

        // 64-bit wrap
        sw(32'h4, 32'hFFFF_FFFF);
        sw(32'h0, 32'hFFFF_FFFF);
        sw(32'h10, 32'h1);
        sw(32'h10, 32'h0);
        ld(32'h0, 3'b010); chk("wrap_lo", rv, 32'd0);
        ld(32'h4, 3'b010); chk("wrap_hi", rv, 32'd0);

        // 4: compare, pending, interrupt, W1C
        sw(32'h0, 32'h0);
        sw(32'h4, 32'h0);
        sw(32'h8, 32'd5);
        sw(32'hC, 32'h0);
        sw(32'h10, 32'h3);
        idle(8);
        ld(32'h14, 3'b010); chk("t4_pending", rv, 32'd1);
        chk("t4_irq", timer_interrupt, 1'b1);
        sw(32'h14, 32'h1);
        ld(32'h14, 3'b010); chk("t4_w1c_match", rv, 32'd1);
        sw(32'hC, 32'h1);
        sw(32'h14, 32'h1);
        ld(32'h14, 3'b010); chk("t4_w1c_clear", rv, 32'd0);
        chk("t4_irq_drop", timer_interrupt, 1'b0);
        sw(32'h10, 32'h0);

        // 5: byte store and sub-word loads
        sw(32'h8, 32'hFFFF_FFFF);
        op(1'b0, 1'b0, 1'b1, BASE + 32'hA, 3'b000, 32'h0000_00A5, rv, ev, hv_o);
        ld(32'h8, 3'b010); chk("t5_lw", rv, 32'hFFA5_FFFF);
        ld(32'hA, 3'b000); chk("t5_lb", rv, 32'hFFFF_FFA5);
        ld(32'hA, 3'b100); chk("t5_lbu", rv, 32'h0000_00A5);
        ld(32'hA, 3'b001); chk("t5_lh", rv, 32'hFFFF_FFA5);

        // 6: errors and out-of-window
        op(1'b0, 1'b1, 1'b0, BASE + 32'h2, 3'b010, 32'h0, rv, ev, hv_o);
        chk("t6_lw_mis_err", ev, 1'b1);
        op(1'b0, 1'b0, 1'b1, BASE + 32'h1, 3'b001, 32'h1234, rv, ev, hv_o);
        chk("t6_sh_mis_err", ev, 1'b1);
        op(1'b0, 1'b1, 1'b0, BASE + 32'd32, 3'b010, 32'h0, rv, ev, hv_o);
        chk("t6_out_hit", hv_o, 1'b0);
        chk("t6_out_rdata", rv, 32'h0);

        // Random traffic against the model, with occasional resets
        for (int i = 0; i < 2000; i++) begin
            rs   = ($urandom_range(0, 299) == 0);
            kind = $urandom_range(0, 19);
            r    = (kind == 0) || (kind >= 3 && kind <= 10);
            w    = (kind == 0) || (kind >= 11);
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = BASE + 32'($urandom_range(0, 35));
            m = 3'($urandom_range(0, 7));
            d = $urandom;
            if ($urandom_range(0, 1) == 1) d[15:8] = 8'($urandom_range(0, 3));
            op(rs, r, w, a, m, d, rv, ev, hv_o);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped machine-timer peripheral and data-bus responder.
- The processor's load/store port is the initiator: rd_en, wr_en, addr, mem_acc_mode and store data, with the load result returned on rdata.
- The block holds a 64-bit mtime counter, a 64-bit mtimecmp register, a prescaler and control/status registers.
- It drives timer_interrupt into csr_reg, replacing the free-running timer, and sits beside data_mem. The top muxes rdata using hit.

Parameters:
- BASE_ADDR, 32'h0000_F000, base of the 32-byte register window (aligned to 32 bytes).
- PRESC_W, 8, width of the prescaler field and prescaler counter.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- rd_en  in  1  load strobe from controller
- wr_en  in  1  store strobe from controller
- addr  in  32  byte address (ALU result)
- mem_acc_mode  in  3  funct3 access mode: 000 B, 001 H, 010 W, 100 BU, 101 HU
- wdata  in  32  store data (rs2 value), LSB-aligned
- rdata  out  32  load data, combinational, extended per mem_acc_mode
- hit  out  1  combinational: addr[31:5]==BASE_ADDR[31:5]
- acc_err  out  1  combinational: hit & (rd_en|wr_en) & misaligned or illegal mode
- timer_interrupt  out  1  registered interrupt level to csr_reg

Behaviour:
Clock and reset:
- Single clock domain. Reset is synchronous and active-high.
- Reset values: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, ctrl=0, presc_cnt=0, pending=0, hi_shadow=0, timer_interrupt=0.
- Combinational outputs under reset follow their inputs and the reset state.

Register map (offset = addr[4:2]); all other offsets read 0 and ignore writes:
- 0 MTIME_LO
- 1 MTIME_HI
- 2 MTIMECMP_LO
- 3 MTIMECMP_HI
- 4 CTRL: [0] en, [1] irq_en, [8+:PRESC_W] presc, others RAZ/WI
- 5 STATUS: [0] pending, write-1-to-clear

Reads:
- Zero latency. rdata is valid in the same cycle as rd_en & hit.
- Byte/half is selected by addr[1:0]. 000/001 sign-extend; 100/101 zero-extend.
- rdata=0 when not hit, not rd_en, or acc_err.
- Reading MTIME_LO (any width) captures mtime[63:32] into hi_shadow at that edge.
- MTIME_HI reads return hi_shadow, not live mtime.

Writes:
- Take effect at the rising edge of the wr_en & hit cycle.
- Byte lanes are selected by mode and addr[1:0]: SB writes 1 lane, SH 2, SW 4. Unaddressed lanes are kept.

Alignment and mode errors:
- Misaligned accesses raise acc_err and do nothing: H with addr[0]=1, or W with addr[1:0]!=0.
- Modes 011, 110, 111 raise acc_err and do nothing.
- Loads with mode 100/101 are legal; stores with mode 100/101/11x are errors.
- rd_en & wr_en both set: treat as a write; acc_err is asserted.

Prescaler and counter:
- When en=1: presc_cnt increments each cycle.
- When presc_cnt==presc: tick=1, presc_cnt<=0, mtime<=mtime+1 (64-bit wrap, FFFF..FF -> 0).
- presc=0 gives a tick every cycle.
- When en=0: presc_cnt is held at 0 and mtime is frozen.
- Writing CTRL resets presc_cnt to 0.

Simultaneous events:
- A write to MTIME_LO/HI in a tick cycle: the write wins for all 64 bits, with no increment that cycle.
- A write to MTIMECMP takes effect the next cycle for the compare.

Compare and interrupt:
- match = (mtime >= mtimecmp), unsigned 64-bit, evaluated on registered values.
- pending is set on any cycle with match=1.
- A STATUS W1C write clears pending unless match is still 1 that cycle (set wins).
- timer_interrupt <= irq_en & pending, so it is 1 cycle after pending.
- Reset in the middle of any of the above restores all reset values at that edge.

Decomposition:
- Package mmio_timer_pkg:
  - mem_acc_mode localparams (MODE_B, MODE_H, MODE_W, MODE_BU, MODE_HU).
  - Register offset enum (REG_MTIME_LO .. REG_STATUS).
  - CTRL bit-index constants.
- Shared with data_mem and controller.
- One sub-module: mmio_lane_ctrl (combinational). It does the alignment check, byte-enable generation, and load extract/extend, and is reusable by data_mem.

Test Plan:
1. Reset, then SW CTRL=32'h0000_0001 (en, presc=0); wait 10 cycles; LW MTIME_LO -> rdata=10 (±1 for write-cycle alignment, fixed by the bench); LW MTIME_HI -> 0.
2. CTRL presc=3, en=1; run 40 cycles -> mtime=10; CTRL en=0 -> mtime frozen for 20 cycles.
3. SW MTIME_LO=FFFF_FFFF, MTIME_HI=0, en, presc=0 -> after 1 tick LW MTIME_LO=0. LW MTIME_HI gives 1, but only after a LO read has refreshed hi_shadow.
4. MTIMECMP=5 (HI=0), CTRL=32'h3 -> pending=1 when mtime reaches 5; timer_interrupt=1 the next cycle. W1C STATUS while match -> pending stays 1. Set MTIMECMP_HI=1, then W1C -> pending=0, then timer_interrupt=0 the next cycle.
5. SB 8'hA5 to MTIMECMP_LO+2 -> LW MTIMECMP_LO=FFA5_FFFF; LB at +2 -> FFFF_FFA5; LBU at +2 -> 0000_00A5; LH at +2 -> FFFF_FFA5.
6. Errors: LW at BASE+2 and SH at BASE+1 -> acc_err=1, rdata=0, no state change. An access at BASE+32 -> hit=0, rdata=0.
